bloom_filter_ctrl: RTL

// Responder side of the parser's bloom interface (bloom_rdy/bloom_wr/index_0/index_1/pkt_is_ack).

---
 rtl/bloom_defs.sv | 19 +
 rtl/bloom_ctr_update.sv | 32 +++
 rtl/bloom_filter_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bloom_defs.sv
// rtl/bloom_defs.sv - shared types and constants for the bloom filter controller
// Holds the one-hot state encoding, counter defaults and the flow tuple width.
package bloom_defs;

  localparam int TUPLE_W       = 96;
  localparam int CTR_WIDTH_DEF = 4;
  localparam logic [CTR_WIDTH_DEF-1:0] CTR_MAX = '1;

  typedef enum logic [6:0] {
    S_CLEAR  = 7'b0000001,
    S_IDLE   = 7'b0000010,
    S_RD0    = 7'b0000100,
    S_RD1    = 7'b0001000,
    S_DECIDE = 7'b0010000,
    S_WR0    = 7'b0100000,
    S_WR1    = 7'b1000000
  } state_t;

endpackage

// File: rtl/bloom_ctr_update.sv
// rtl/bloom_ctr_update.sv - saturating increment/decrement of one bloom counter
// A counter at all-ones is frozen; sat flags an insert that would have wrapped.
module bloom_ctr_update
  import bloom_defs::*;
#(
  parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 op_inc,
  output logic [CTR_WIDTH-1:0] new_ctr,
  output logic                 sat
);

  localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

  logic at_max;

  assign at_max = &ctr;

  always_comb begin
    new_ctr = ctr;
    sat     = 1'b0;
    if (at_max) begin
      sat = op_inc;
    end else if (op_inc) begin
      new_ctr = ctr + ONE;
    end else begin
      new_ctr = ctr - ONE;
    end
  end

endmodule

// File: rtl/bloom_filter_ctrl.sv
// rtl/bloom_filter_ctrl.sv - counting bloom filter controller over external SRAM
// Clears the SRAM after reset, then services parser insert/query requests.
module bloom_filter_ctrl
  import bloom_defs::*;
#(
  parameter int HASH_BITS       = 19,
  parameter int CTR_WIDTH       = CTR_WIDTH_DEF,
  parameter int SRAM_DATA_WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bloom_wr,
  output logic                       bloom_rdy,
  input  logic [HASH_BITS-1:0]       index_0,
  input  logic [HASH_BITS-1:0]       index_1,
  input  logic                       pkt_is_ack,
  input  logic [TUPLE_W-1:0]         wire_tuple,
  output logic                       sram_req,
  output logic                       sram_rd_wr_L,
  output logic [HASH_BITS-1:0]       sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic                       sram_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  output logic                       ack_hit,
  output logic                       ack_miss,
  output logic [TUPLE_W-1:0]         miss_tuple,
  output logic [31:0]                num_insert,
  output logic [31:0]                num_hit,
  output logic [31:0]                num_miss,
  output logic [31:0]                num_sat
);

  state_t                     state, state_nx;
  logic [HASH_BITS-1:0]       clr_addr, clr_nx, idx0, idx1, nidx0, addr_nx;
  logic                       is_ack, same, hit, accept, last_clr;
  logic [TUPLE_W-1:0]         tuple;
  logic [CTR_WIDTH-1:0]       c0, c1, n0, n1;
  logic                       s0, s1, req_nx, rdwr_nx;
  logic [SRAM_DATA_WIDTH-1:0] wdata_nx;
  logic                       unused_rd;

  assign same      = idx0 == idx1;
  assign hit       = (c0 != '0) && (c1 != '0);
  assign accept    = (state == S_IDLE) && bloom_wr;
  assign last_clr  = &clr_addr;
  assign clr_nx    = (state == S_CLEAR && sram_ack) ? clr_addr + HASH_BITS'(1) : clr_addr;
  assign nidx0     = accept ? index_0 : idx0;
  assign unused_rd = ^sram_rd_data[SRAM_DATA_WIDTH-1:CTR_WIDTH];

  bloom_ctr_update #(.CTR_WIDTH(CTR_WIDTH)) u_upd0 (
    .ctr(c0), .op_inc(!is_ack), .new_ctr(n0), .sat(s0)
  );
  bloom_ctr_update #(.CTR_WIDTH(CTR_WIDTH)) u_upd1 (
    .ctr(c1), .op_inc(!is_ack), .new_ctr(n1), .sat(s1)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR:  if (sram_ack && last_clr) state_nx = S_IDLE;
      S_IDLE:   if (bloom_wr) state_nx = S_RD0;
      S_RD0:    if (sram_ack) state_nx = same ? S_DECIDE : S_RD1;
      S_RD1:    if (sram_ack) state_nx = S_DECIDE;
      S_DECIDE: state_nx = (!is_ack || hit) ? S_WR0 : S_IDLE;
      S_WR0:    if (sram_ack) state_nx = same ? S_IDLE : S_WR1;
      S_WR1:    if (sram_ack) state_nx = S_IDLE;
      default:  state_nx = S_CLEAR;
    endcase
  end

  // SRAM signals are registered from the next state so they stay put while a request waits.
  always_comb begin
    req_nx   = 1'b0;
    rdwr_nx  = 1'b0;
    addr_nx  = '0;
    wdata_nx = '0;
    case (state_nx)
      S_CLEAR: begin req_nx = 1'b1; addr_nx = clr_nx; end
      S_RD0:   begin req_nx = 1'b1; rdwr_nx = 1'b1; addr_nx = nidx0; end
      S_RD1:   begin req_nx = 1'b1; rdwr_nx = 1'b1; addr_nx = idx1; end
      S_WR0:   begin req_nx = 1'b1; addr_nx = idx0; wdata_nx = SRAM_DATA_WIDTH'(n0); end
      S_WR1:   begin req_nx = 1'b1; addr_nx = idx1; wdata_nx = SRAM_DATA_WIDTH'(n1); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr     <= '0;
      idx0         <= '0;
      idx1         <= '0;
      is_ack       <= 1'b0;
      tuple        <= '0;
      c0           <= '0;
      c1           <= '0;
      bloom_rdy    <= 1'b0;
      sram_req     <= 1'b0;
      sram_rd_wr_L <= 1'b0;
      sram_addr    <= '0;
      sram_wr_data <= '0;
      ack_hit      <= 1'b0;
      ack_miss     <= 1'b0;
      miss_tuple   <= '0;
      num_insert   <= '0;
      num_hit      <= '0;
      num_miss     <= '0;
      num_sat      <= '0;
    end else begin
      clr_addr     <= clr_nx;
      bloom_rdy    <= state_nx == S_IDLE;
      sram_req     <= req_nx;
      sram_rd_wr_L <= rdwr_nx;
      sram_addr    <= addr_nx;
      sram_wr_data <= wdata_nx;
      ack_hit      <= 1'b0;
      ack_miss     <= 1'b0;
      if (accept) begin
        idx0   <= index_0;
        idx1   <= index_1;
        is_ack <= pkt_is_ack;
        tuple  <= wire_tuple;
      end
      // A shared index reads once; both counter slots carry the same value.
      if (state == S_RD0 && sram_ack) begin
        c0 <= sram_rd_data[CTR_WIDTH-1:0];
        if (same) c1 <= sram_rd_data[CTR_WIDTH-1:0];
      end
      if (state == S_RD1 && sram_ack) c1 <= sram_rd_data[CTR_WIDTH-1:0];
      if (state == S_DECIDE) begin
        if (!is_ack) begin
          num_insert <= num_insert + 32'd1;
          num_sat    <= num_sat + 32'(s0) + 32'(s1 && !same);
        end else if (hit) begin
          ack_hit <= 1'b1;
          num_hit <= num_hit + 32'd1;
        end else begin
          ack_miss   <= 1'b1;
          num_miss   <= num_miss + 32'd1;
          miss_tuple <= tuple;
        end
      end
    end
  end

endmodule
